// File: rtl/histogram_renderer.sv
// Bar-graph pixel generator: frame-latched bin heights, per-bin peak-hold markers
// and selectable display modes, rendered through a 2-stage pixel pipeline.

module histogram_bin_lane #(
    parameter int AMP_W       = 12,
    parameter int SCALE_SHIFT = 7,
    parameter int NUM_ROWS    = 30,
    parameter int HOLD_FRAMES = 30,
    parameter int HT_W        = 5
) (
    input  logic             clk_25MHz,
    input  logic             rst,
    input  logic             latch,
    input  logic [AMP_W-1:0] amp,
    output logic [HT_W-1:0]  height,
    output logic [HT_W-1:0]  peak
);
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    logic [AMP_W-1:0]  scaled;
    logic [HT_W-1:0]   h_new;
    logic [HOLD_W-1:0] hold;

    assign scaled = amp >> SCALE_SHIFT;
    assign h_new  = (scaled > AMP_W'(NUM_ROWS)) ? HT_W'(NUM_ROWS) : scaled[HT_W-1:0];

    always_ff @(posedge clk_25MHz) begin
        if (!rst) begin
            height <= '0;
            peak   <= '0;
            hold   <= '0;
        end else if (latch) begin
            height <= h_new;
            // an equal height does not refresh the hold timer
            if (h_new > peak) begin
                peak <= h_new;
                hold <= '0;
            end else if (hold < HOLD_W'(HOLD_FRAMES)) begin
                hold <= hold + HOLD_W'(1);
            end else if (peak != '0) begin
                peak <= peak - HT_W'(1);
            end
        end
    end
endmodule

module histogram_renderer #(
    parameter int NUM_BINS    = 16,
    parameter int AMP_W       = 12,
    parameter int SCALE_SHIFT = 7,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int ROW_SHIFT   = 4,
    parameter int HOLD_FRAMES = 30
) (
    input  logic                      clk_25MHz,
    input  logic                      rst,
    input  logic [9:0]                hc_in,
    input  logic [9:0]                vc_in,
    input  logic [NUM_BINS*AMP_W-1:0] bin_amplitudes,
    input  logic [1:0]                mode,
    input  logic                      gap_en,
    output logic [7:0]                color_out,
    output logic                      frame_latched
);
    localparam int NUM_ROWS = V_ACTIVE >> ROW_SHIFT;
    localparam int BAR_W    = H_ACTIVE / NUM_BINS;
    localparam int BIN_W    = $clog2(NUM_BINS);
    localparam int PX_W     = $clog2(BAR_W + 1);
    localparam int HT_W     = $clog2(NUM_ROWS + 1);
    localparam int G_SH     = $clog2(NUM_BINS / 16);

    logic [NUM_BINS-1:0][HT_W-1:0] heights;
    logic [NUM_BINS-1:0][HT_W-1:0] peaks;
    logic                          latch_evt;

    logic [PX_W-1:0]  px_cnt;
    logic [BIN_W-1:0] bin;
    logic             s1_active;
    logic [9:0]       s1_row;
    logic [1:0]       s1_mode;
    logic             s1_gap;
    logic [HT_W-1:0]  cur_h;
    logic [HT_W-1:0]  cur_pk;
    logic [7:0]       pix;

    function automatic logic [7:0] gradient(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'hE0;
            4'd1:    return 8'hC4;
            4'd2:    return 8'hA8;
            4'd3:    return 8'h8C;
            4'd4:    return 8'h70;
            4'd5:    return 8'h54;
            4'd6:    return 8'h38;
            4'd7:    return 8'h1C;
            4'd8:    return 8'h18;
            4'd9:    return 8'h1A;
            4'd10:   return 8'h1E;
            4'd11:   return 8'h1F;
            4'd12:   return 8'h3F;
            4'd13:   return 8'h5F;
            4'd14:   return 8'h7F;
            default: return 8'h9F;
        endcase
    endfunction

    // freeze mode blocks the whole latch, peaks included
    assign latch_evt = (hc_in == 10'd0) && (vc_in == 10'(V_ACTIVE)) && (mode != 2'd3);

    for (genvar i = 0; i < NUM_BINS; i++) begin : g_lane
        histogram_bin_lane #(
            .AMP_W(AMP_W), .SCALE_SHIFT(SCALE_SHIFT), .NUM_ROWS(NUM_ROWS),
            .HOLD_FRAMES(HOLD_FRAMES), .HT_W(HT_W)
        ) u_lane (
            .clk_25MHz(clk_25MHz),
            .rst      (rst),
            .latch    (latch_evt),
            .amp      (bin_amplitudes[i*AMP_W +: AMP_W]),
            .height   (heights[i]),
            .peak     (peaks[i])
        );
    end

    assign cur_h  = heights[bin];
    assign cur_pk = peaks[bin];

    always_comb begin
        pix = 8'h00;
        if (s1_active && !(s1_gap && px_cnt == PX_W'(BAR_W - 1))) begin
            if (s1_mode != 2'd0 && cur_pk != '0 &&
                s1_row == 10'(NUM_ROWS) - 10'(cur_pk))
                pix = 8'hFF;
            else if (s1_mode != 2'd2 && s1_row >= 10'(NUM_ROWS) - 10'(cur_h))
                pix = gradient(4'(bin >> G_SH));
        end
    end

    // stage 1 holds the column/row of the captured pixel, stage 2 the colour
    always_ff @(posedge clk_25MHz) begin
        if (!rst) begin
            px_cnt        <= '0;
            bin           <= '0;
            s1_active     <= 1'b0;
            s1_row        <= '0;
            s1_mode       <= '0;
            s1_gap        <= 1'b0;
            color_out     <= 8'h00;
            frame_latched <= 1'b0;
        end else begin
            frame_latched <= latch_evt;
            s1_active     <= (hc_in < 10'(H_ACTIVE)) && (vc_in < 10'(V_ACTIVE));
            s1_row        <= vc_in >> ROW_SHIFT;
            s1_mode       <= mode;
            s1_gap        <= gap_en;
            if (hc_in == 10'd0) begin
                px_cnt <= '0;
                bin    <= '0;
            end else if (hc_in < 10'(H_ACTIVE)) begin
                if (px_cnt == PX_W'(BAR_W - 1)) begin
                    px_cnt <= '0;
                    if (bin != BIN_W'(NUM_BINS - 1))
                        bin <= bin + BIN_W'(1);
                end else begin
                    px_cnt <= px_cnt + PX_W'(1);
                end
            end
            color_out <= pix;
        end
    end
endmodule

// File: tb/tb_histogram_renderer.sv
// Drives two renderers (16 and 64 bins) with directed and random line/frame traffic
// and checks every output cycle against a frame-level behavioural model.

module tb_histogram_renderer;
    localparam int VA = 480;
    localparam int NR = 30;

    logic clk_25MHz = 1'b0;
    always #20 clk_25MHz = ~clk_25MHz;

    logic             rst;
    logic [9:0]       hc_in, vc_in;
    logic [1:0]       mode;
    logic             gap_en;
    logic [16*12-1:0] amp_a;
    logic [64*12-1:0] amp_b;
    logic [7:0]       col_a, col_b;
    logic             fl_a, fl_b;

    histogram_renderer dut_a (
        .clk_25MHz(clk_25MHz), .rst(rst), .hc_in(hc_in), .vc_in(vc_in),
        .bin_amplitudes(amp_a), .mode(mode), .gap_en(gap_en),
        .color_out(col_a), .frame_latched(fl_a)
    );

    histogram_renderer #(.NUM_BINS(64)) dut_b (
        .clk_25MHz(clk_25MHz), .rst(rst), .hc_in(hc_in), .vc_in(vc_in),
        .bin_amplitudes(amp_b), .mode(mode), .gap_en(gap_en),
        .color_out(col_b), .frame_latched(fl_b)
    );

    int checks = 0;
    int failures = 0;
    int pulses_a = 0;
    int amp  [2][64];
    int h    [2][64];
    int pk   [2][64];
    int hold [2][64];
    logic [7:0] prev_exp [2];
    logic [7:0] obs [2][1024];
    int prev_hc = 0;
    logic [7:0] grad [16] = '{8'hE0, 8'hC4, 8'hA8, 8'h8C, 8'h70, 8'h54, 8'h38, 8'h1C,
                              8'h18, 8'h1A, 8'h1E, 8'h1F, 8'h3F, 8'h5F, 8'h7F, 8'h9F};

    function automatic int nbins(int c);
        return (c == 0) ? 16 : 64;
    endfunction

    function automatic logic [7:0] model_pixel(int c, int x, int y);
        int n, bw, b, row;
        n = nbins(c);
        bw = 640 / n;
        if (x >= 640 || y >= VA) return 8'h00;
        b = x / bw;
        if (b > n - 1) b = n - 1;
        row = y / 16;
        if (gap_en && (x % bw) == bw - 1) return 8'h00;
        if (mode != 0 && pk[c][b] > 0 && row == NR - pk[c][b]) return 8'hFF;
        if (mode != 2 && row >= NR - h[c][b]) return grad[b / (n / 16)];
        return 8'h00;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_latch();
        int hn;
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < nbins(c); i++) begin
                hn = amp[c][i] / 128;
                if (hn > NR) hn = NR;
                h[c][i] = hn;
                if (hn > pk[c][i]) begin
                    pk[c][i] = hn;
                    hold[c][i] = 0;
                end else if (hold[c][i] < 30) hold[c][i]++;
                else if (pk[c][i] > 0) pk[c][i]--;
            end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 64; i++) begin
                h[c][i] = 0; pk[c][i] = 0; hold[c][i] = 0;
            end
    endtask

    task automatic set_all(input int c, input int v);
        for (int i = 0; i < 64; i++) amp[c][i] = v;
    endtask

    // one pixel clock: apply inputs, advance, check outputs of the earlier pixels
    task automatic step(input int x, input int y);
        logic [7:0] e0, e1;
        logic el;
        hc_in = 10'(x);
        vc_in = 10'(y);
        for (int i = 0; i < 16; i++) amp_a[i*12 +: 12] = 12'(amp[0][i]);
        for (int i = 0; i < 64; i++) amp_b[i*12 +: 12] = 12'(amp[1][i]);
        e0 = model_pixel(0, x, y);
        e1 = model_pixel(1, x, y);
        el = rst && x == 0 && y == VA && mode != 2'd3;
        if (!rst) begin
            model_reset();
            e0 = 8'h00; e1 = 8'h00;
            prev_exp[0] = 8'h00; prev_exp[1] = 8'h00;
        end else if (el) model_latch();
        @(posedge clk_25MHz);
        @(negedge clk_25MHz);
        chk("frame_latched_a", int'(fl_a), int'(el));
        chk("frame_latched_b", int'(fl_b), int'(el));
        chk("color_a", int'(col_a), int'(prev_exp[0]));
        chk("color_b", int'(col_b), int'(prev_exp[1]));
        obs[0][prev_hc] = col_a;
        obs[1][prev_hc] = col_b;
        if (fl_a) pulses_a++;
        prev_exp[0] = e0;
        prev_exp[1] = e1;
        prev_hc = x;
    endtask

    task automatic run_line(input int y, input int len);
        for (int x = 0; x <= len; x++) step(x, y);
    endtask

    task automatic latch_line();
        for (int x = 0; x < 4; x++) step(x, VA);
    endtask

    initial begin
        int p0, nl;
        rst = 1'b0; mode = 2'd0; gap_en = 1'b0;
        hc_in = '0; vc_in = '0;
        prev_exp[0] = 8'h00; prev_exp[1] = 8'h00;
        set_all(0, 0); set_all(1, 0);
        model_reset();
        for (int i = 0; i < 3; i++) step(0, 0);
        chk("reset_color", int'(col_a), 0);
        chk("reset_latched", int'(fl_a), 0);
        rst = 1'b1;

        // uniform height 15: lower half of the screen lit
        set_all(0, 'h780); set_all(1, 'h780);
        latch_line();
        run_line(240, 644);
        chk("bar_bin0_x0", int'(obs[0][0]), 'hE0);
        chk("bar_bin0_x39", int'(obs[0][39]), 'hE0);
        chk("bar_bin1_x40", int'(obs[0][40]), 'hC4);
        run_line(239, 50);
        chk("bar_above_top", int'(obs[0][0]), 'h00);
        latch_line();
        chk("pulse_per_frame", pulses_a, 2);

        // saturation and zero
        amp[0][3] = 'hFFF; amp[0][4] = 0;
        latch_line();
        run_line(0, 170);
        chk("sat_bin3_top", int'(obs[0][120]), 'h8C);
        chk("zero_bin4_top", int'(obs[0][160]), 'h00);
        run_line(479, 170);
        chk("sat_bin3_bot", int'(obs[0][159]), 'h8C);
        chk("zero_bin4_bot", int'(obs[0][165]), 'h00);

        // inputs changing mid-frame stay invisible until the next latch
        set_all(0, 'h780);
        latch_line();
        run_line(200, 50);
        set_all(0, 0);
        run_line(300, 50);
        chk("tear_same_frame", int'(obs[0][0]), 'hE0);
        latch_line();
        run_line(300, 50);
        chk("tear_next_frame", int'(obs[0][0]), 'h00);

        // peak hold and decay on bin 0
        mode = 2'd1;
        amp[0][0] = 'hFFF;
        latch_line();
        amp[0][0] = 0;
        for (int f = 0; f <= 61; f++) begin
            run_line(0, 12);
            if (f == 30) chk("peak_row0_last_hold", int'(obs[0][5]), 'hFF);
            if (f == 31) chk("peak_row0_gone", int'(obs[0][5]), 'h00);
            run_line(16, 12);
            if (f == 31) chk("peak_row1_first_decay", int'(obs[0][5]), 'hFF);
            run_line(464, 12);
            if (f == 59) chk("peak_row29", int'(obs[0][5]), 'hFF);
            if (f == 60) chk("peak_cleared", int'(obs[0][5]), 'h00);
            latch_line();
        end

        // freeze, then reset mid-line
        mode = 2'd0;
        set_all(0, 'h780);
        latch_line();
        mode = 2'd3;
        run_line(300, 50);
        chk("freeze_before", int'(obs[0][0]), 'hE0);
        set_all(0, 0);
        p0 = pulses_a;
        latch_line();
        chk("freeze_no_pulse", pulses_a - p0, 0);
        run_line(300, 50);
        chk("freeze_after", int'(obs[0][0]), 'hE0);
        for (int x = 0; x < 30; x++) begin
            rst = (x != 10);
            step(x, 300);
        end
        rst = 1'b1;
        run_line(300, 50);
        chk("post_reset_black", int'(obs[0][0]), 'h00);
        mode = 2'd2;
        latch_line();
        run_line(0, 50);
        chk("post_reset_no_peak", int'(obs[0][5]), 'h00);

        // 64 bins with gap columns
        mode = 2'd0; gap_en = 1'b1;
        set_all(1, 'hFFF);
        latch_line();
        run_line(100, 644);
        chk("b64_bin0_body", int'(obs[1][8]), 'hE0);
        chk("b64_gap9", int'(obs[1][9]), 'h00);
        chk("b64_bin5", int'(obs[1][50]), 'hC4);
        chk("b64_gap59", int'(obs[1][59]), 'h00);
        chk("b64_bin63", int'(obs[1][635]), 'h9F);
        chk("b64_gap639", int'(obs[1][639]), 'h00);

        // random frames against the model
        for (int f = 0; f < 20; f++) begin
            for (int c = 0; c < 2; c++)
                for (int i = 0; i < 64; i++)
                    amp[c][i] = int'($urandom_range(0, 4095));
            nl = int'($urandom_range(1, 3));
            for (int l = 0; l < nl; l++) begin
                mode   = 2'($urandom_range(0, 3));
                gap_en = 1'($urandom_range(0, 1));
                run_line(int'($urandom_range(0, VA - 1)), int'($urandom_range(20, 660)));
            end
            mode = 2'($urandom_range(0, 4) == 0 ? 3 : $urandom_range(0, 2));
            latch_line();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/histogram_renderer.md
Name: histogram_renderer

Overview:
- Parametrised bar-graph pixel generator for the VGA path.
- Sits between the bin-amplitude source (FFT/time-sample binning) and the vga timing/DAC module.
- Consumes the vga module's hc/vc counters and produces a registered 8-bit RRRGGGBB colour per pixel.
- Adds three things over the single-mode 16-bar renderer:
  - tear-free frame-synchronous latching of amplitudes;
  - per-bin peak-hold markers with timed decay;
  - selectable display modes with a configurable bin count.

Parameters:
- NUM_BINS, 16, number of bars; legal values are 16, 32 and 64.
- AMP_W, 12, width of each bin amplitude.
- SCALE_SHIFT, 7, right shift that converts an amplitude to a bar height in rows.
- H_ACTIVE, 640, active pixels per line; must be divisible by NUM_BINS.
- V_ACTIVE, 480, active lines per frame.
- ROW_SHIFT, 4, log2 of pixel lines per row. NUM_ROWS = V_ACTIVE >> ROW_SHIFT, which is 30 at the defaults.
- HOLD_FRAMES, 30, frames a peak is held before it starts to decay.

Ports:
- clk_25MHz  in  1  pixel clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-low reset.
- hc_in  in  10  horizontal counter from vga; increments by 1 per clock and returns to 0 at line start.
- vc_in  in  10  vertical counter from vga.
- bin_amplitudes  in  AMP_W x NUM_BINS  live bin amplitudes; may change at any time.
- mode  in  2  display mode:
  - 0: bars only;
  - 1: bars plus peak markers;
  - 2: peak markers only;
  - 3: freeze (display the last latched frame, with peaks).
- gap_en  in  1  when 1, the last pixel column of each bar is drawn black.
- color_out  out  8  RRRGGGBB pixel colour.
- frame_latched  out  1  one-cycle pulse when the shadow registers update.

Behaviour:
- Reset (rst=0 at a clock edge) clears:
  - all shadow heights, peak registers and hold counters;
  - the column counter and bin index;
  - color_out=8'h00 and frame_latched=0.
- Reset asserted mid-frame: output is black from the next cycle until the first latch after release.
- Latch event: occurs when hc_in==0 and vc_in==V_ACTIVE (first vblank line).
  - In modes 0-2, each shadow height h[i] = min(bin_amplitudes[i] >> SCALE_SHIFT, NUM_ROWS).
  - frame_latched pulses high in the cycle after the event.
  - Mode 3 suppresses the latch entirely: no shadow update, no peak update and no pulse.
- Shadow heights are the only amplitude source for rendering. Input changes during active video never affect the current frame.
- Peak update, performed at each latch for every bin:
  - If h_new > peak[i]: peak = h_new and hold = 0.
  - Otherwise, if hold < HOLD_FRAMES: hold increments.
  - Otherwise: peak decrements by 1 per latch, floored at 0.
  - When h_new == peak, the hold counter keeps counting; it is not refreshed.
- Column tracking:
  - px_cnt and bin reset to 0 when hc_in==0.
  - While hc_in < H_ACTIVE, px_cnt increments each cycle.
  - At px_cnt == BAR_W-1 (BAR_W = H_ACTIVE/NUM_BINS), px_cnt wraps to 0 and bin increments.
  - bin saturates at NUM_BINS-1. No divider is used.
- Row index: row = vc_in >> ROW_SHIFT.
- Pixel decision, in priority order:
  1. If outside the active area (hc_in ≥ H_ACTIVE or vc_in ≥ V_ACTIVE): 8'h00.
  2. If gap_en and px_cnt == BAR_W-1: 8'h00.
  3. Peak marker: when mode is 1, 2 or 3, peak > 0, and row == NUM_ROWS - peak, output 8'hFF.
  4. Bar body: when mode is 0, 1 or 3, and row ≥ NUM_ROWS - h[bin], output gradient[bin >> log2(NUM_BINS/16)].
  5. Otherwise: 8'h00.
- Gradient ROM: 16 fixed entries, indices 0..15: E0 C4 A8 8C 70 54 38 1C 18 1A 1E 1F 3F 5F 7F 9F (hex).
- Latency: 2-stage pipeline, so color_out reflects the hc_in/vc_in presented 2 cycles earlier. The vga module compensates by delaying hsync/vsync by 2 cycles.
- A height of 0 draws no bar. A height equal to NUM_ROWS fills all rows.
- A mode change takes effect on pixel decisions within 2 cycles. Its effect on latching starts at the next latch event.

Test Plan:
- Bar heights: defaults; all bins = 12'h780 (>>7 = 15); one frame after reset.
  - Bin 0, at pixels x 0..39 and lines 240..479, outputs E0 after 2-cycle latency.
  - Lines 0..239 are 00.
  - frame_latched pulses exactly once per frame.
- Saturation and zero: bin 3 = 12'hFFF and bin 4 = 0.
  - Bin 3 is filled for all 480 lines with colour 8C.
  - Bin 4 is black on every line.
- Peak decay: mode 1; bin 0 = 12'hFFF for 1 frame, then 0.
  - Marker 8'hFF appears on row 0 for 31 frames (the frame after the rise plus 30 hold frames), then steps down one row per frame.
  - The marker disappears once peak reaches 0.
- Tearing: change bin_amplitudes mid-frame at line 200.
  - The current frame's output is unchanged.
  - The new values appear only after the next latch.
- Freeze and reset: mode 3, then inputs change; assert rst=0 for 1 cycle mid-line.
  - In freeze, the image stays constant and frame_latched stays 0.
  - After reset, color_out=00 until the first latch, and peaks are cleared.
- NUM_BINS=64 with gap_en=1:
  - BAR_W=10, so pixel 9 of each bar is 00.
  - Bin 5 uses gradient[1] = C4.
